// File: rtl/weight_buf_pkg.sv
// -----------------------------------------------------------------------------
// weight_buf_pkg
// Shared types and constants for the weight_buffer block.
//   state_t    : fill FSM states
//   LANES      : number of weight lanes delivered per loader beat
//   LOADER_LAT : cycles from load_start to the loader's first weight beat
//   cnt_width  : width of a counter that must reach the value 'depth'
// -----------------------------------------------------------------------------
package weight_buf_pkg;

   localparam int LANES      = 4;
   localparam int LOADER_LAT = 2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_DRAIN,
      ST_HOLD
   } state_t;

   // Counters count up to 'depth' inclusive, so they need one extra code point.
   function automatic int cnt_width(input int depth);
      return (depth < 1) ? 1 : $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/weight_buffer_if.sv
// -----------------------------------------------------------------------------
// weight_buffer_if
// Loader-side and PE-side signals of the weight buffer.
//   fill_req           : controller wants the next kernel set loaded (level)
//   load_start         : one-cycle pulse starting a loader burst
//   weight_load_done   : one-cycle pulse ending the loader burst
//   weight0..weight3   : lane data from the loader
//   weight_vld         : lane data valid
//   kernel0..kernel3   : front-bank kernels, beat i at [i*WEIGHT_WIDTH +: WEIGHT_WIDTH]
//   kernel_vld         : front bank holds a complete kernel set
//   kernel_rdy         : PE array accepts the front kernel set
//   busy               : fill FSM is not idle
// Modports: slave = the weight buffer, master = its environment.
// -----------------------------------------------------------------------------
interface weight_buffer_if #(
   parameter int WEIGHT_WIDTH = 8,
   parameter int KERNEL_SIZE  = 9
);
   logic                                  fill_req;
   logic                                  load_start;
   logic                                  weight_load_done;
   logic [WEIGHT_WIDTH-1:0]               weight0;
   logic [WEIGHT_WIDTH-1:0]               weight1;
   logic [WEIGHT_WIDTH-1:0]               weight2;
   logic [WEIGHT_WIDTH-1:0]               weight3;
   logic                                  weight_vld;
   logic [KERNEL_SIZE*WEIGHT_WIDTH-1:0]   kernel0;
   logic [KERNEL_SIZE*WEIGHT_WIDTH-1:0]   kernel1;
   logic [KERNEL_SIZE*WEIGHT_WIDTH-1:0]   kernel2;
   logic [KERNEL_SIZE*WEIGHT_WIDTH-1:0]   kernel3;
   logic                                  kernel_vld;
   logic                                  kernel_rdy;
   logic                                  busy;

   modport slave (
      input  fill_req, weight0, weight1, weight2, weight3, weight_vld, kernel_rdy,
      output load_start, weight_load_done, kernel0, kernel1, kernel2, kernel3,
             kernel_vld, busy
   );

   modport master (
      output fill_req, weight0, weight1, weight2, weight3, weight_vld, kernel_rdy,
      input  load_start, weight_load_done, kernel0, kernel1, kernel2, kernel3,
             kernel_vld, busy
   );
endinterface

// File: rtl/weight_bank.sv
// -----------------------------------------------------------------------------
// weight_bank
// One kernel bank: LANES x KERNEL_SIZE weight registers.
//   clk, rst  : clock, synchronous active-high reset (clears the bank)
//   i_we      : write one beat (all lanes) into slot i_slot
//   i_slot    : slot index, 0..KERNEL_SIZE-1
//   i_lanes   : lane data for the beat
//   o_kernel  : flattened per-lane kernels, slot i at [i*WEIGHT_WIDTH +: WEIGHT_WIDTH]
// -----------------------------------------------------------------------------
module weight_bank
   import weight_buf_pkg::*;
#(
   parameter int WEIGHT_WIDTH = 8,
   parameter int KERNEL_SIZE  = 9,
   parameter int CNT_W        = cnt_width(KERNEL_SIZE)
) (
   input  logic                                           clk,
   input  logic                                           rst,
   input  logic                                           i_we,
   input  logic [CNT_W-1:0]                               i_slot,
   input  logic [LANES-1:0][WEIGHT_WIDTH-1:0]             i_lanes,
   output logic [LANES-1:0][KERNEL_SIZE*WEIGHT_WIDTH-1:0] o_kernel
);

   logic [LANES-1:0][KERNEL_SIZE*WEIGHT_WIDTH-1:0] r_kernel;

   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the bank is reset on purpose so the kernels read zero out of
         // reset; this keeps it in flops rather than a RAM macro.
         r_kernel <= '0;
      end else if (i_we) begin
         // Slot decode by comparison keeps out-of-range indices harmless.
         for (int s = 0; s < KERNEL_SIZE; s++) begin
            if (i_slot == CNT_W'(s)) begin
               for (int l = 0; l < LANES; l++) begin
                  // NOTE: non-blocking assignment for every flop, so all
                  // registers update together at the edge.
                  r_kernel[l][s*WEIGHT_WIDTH +: WEIGHT_WIDTH] <= i_lanes[l];
               end
            end
         end
      end
   end

   assign o_kernel = r_kernel;

endmodule

// File: rtl/weight_buffer.sv
// -----------------------------------------------------------------------------
// weight_buffer
// Requests a kernel set from the weight loader, counts the four-lane weight
// stream into a fill bank, ends the loader burst with a timed
// weight_load_done pulse and presents the completed set to the PE array
// through the kernel_vld/kernel_rdy handshake.
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : weight_buffer_if.slave (loader and PE-array signals)
// Build option: WEIGHT_BUF_DOUBLE_EN selects two ping-pong banks so the next
// kernel set loads while the front set is in use; otherwise one bank is used
// and a fill only starts while nothing is presented.
// -----------------------------------------------------------------------------
module weight_buffer
   import weight_buf_pkg::*;
#(
   parameter int WEIGHT_WIDTH = 8,
   parameter int KERNEL_SIZE  = 9
) (
   input  logic           clk,
   input  logic           rst,
   weight_buffer_if.slave bus
);

   localparam int               CNT_W  = cnt_width(KERNEL_SIZE);
   localparam int               KW     = KERNEL_SIZE * WEIGHT_WIDTH;
   localparam logic [CNT_W-1:0] K_CNT  = CNT_W'(KERNEL_SIZE);
   localparam logic [CNT_W-1:0] K_LAST = CNT_W'(KERNEL_SIZE - 1);
`ifdef WEIGHT_BUF_DOUBLE_EN
   localparam int NBANKS = 2;
`else
   localparam int NBANKS = 1;
`endif

   state_t              r_state, w_state_next;
   logic [CNT_W-1:0]    r_issue_cnt, w_issue_cnt_next;
   logic [CNT_W-1:0]    r_rx_cnt, w_rx_cnt_next;
   logic                r_load_start, w_load_start_next;
   logic                r_load_done, w_load_done_next;
   logic                r_kernel_vld, w_kernel_vld_next;
`ifdef WEIGHT_BUF_DOUBLE_EN
   logic                r_front_sel, w_front_sel_next;   // bank presented to the PEs
   logic                r_back_full, w_back_full_next;   // fill bank complete, waiting
`endif

   logic                w_hs, w_rx_en, w_fill_done, w_front_free, w_fill_free;
   logic [NBANKS-1:0]   w_bank_we;
   logic [LANES-1:0][WEIGHT_WIDTH-1:0] w_lanes;
   logic [LANES-1:0][KW-1:0]           w_bank_kernel [NBANKS];
   logic [LANES-1:0][KW-1:0]           w_front;

   assign w_lanes = {bus.weight3, bus.weight2, bus.weight1, bus.weight0};
   assign w_hs    = r_kernel_vld && bus.kernel_rdy;
   assign w_rx_en = ((r_state == ST_ISSUE) || (r_state == ST_DRAIN)) &&
                    bus.weight_vld && (r_rx_cnt < K_CNT);
   // The last beat completes the bank in the cycle it is written, which lets
   // kernel_vld rise on the cycle right after that beat.
   assign w_fill_done  = (r_rx_cnt == K_CNT) || (w_rx_en && (r_rx_cnt == K_LAST));
   // A front set being accepted this cycle counts as empty: no bubble.
   assign w_front_free = !r_kernel_vld || w_hs;

`ifdef WEIGHT_BUF_DOUBLE_EN
   assign w_fill_free = !r_back_full;
   assign w_bank_we   = w_rx_en ? (r_front_sel ? 2'b01 : 2'b10) : 2'b00;
   assign w_front     = r_front_sel ? w_bank_kernel[1] : w_bank_kernel[0];
`else
   assign w_fill_free = !r_kernel_vld;
   assign w_bank_we   = w_rx_en;
   assign w_front     = w_bank_kernel[0];
`endif

   for (genvar b = 0; b < NBANKS; b++) begin : g_bank
      weight_bank #(
         .WEIGHT_WIDTH (WEIGHT_WIDTH),
         .KERNEL_SIZE  (KERNEL_SIZE),
         .CNT_W        (CNT_W)
      ) u_bank (
         .clk      (clk),
         .rst      (rst),
         .i_we     (w_bank_we[b]),
         .i_slot   (r_rx_cnt),
         .i_lanes  (w_lanes),
         .o_kernel (w_bank_kernel[b])
      );
   end

   always_comb begin
      // NOTE: every signal gets a default before the case, so no path leaves
      // one unassigned and no latch is inferred.
      w_state_next      = r_state;
      w_issue_cnt_next  = r_issue_cnt;
      w_rx_cnt_next     = r_rx_cnt;
      w_load_start_next = 1'b0;
      w_load_done_next  = 1'b0;
      w_kernel_vld_next = r_kernel_vld && !w_hs;
`ifdef WEIGHT_BUF_DOUBLE_EN
      w_front_sel_next  = r_front_sel;
      w_back_full_next  = r_back_full;
`endif
      if (w_rx_en) begin
         w_rx_cnt_next = r_rx_cnt + 1'b1;
      end

      unique case (r_state)
         ST_IDLE: begin
            if (bus.fill_req && w_fill_free) begin
               w_load_start_next = 1'b1;
               w_issue_cnt_next  = '0;
               w_rx_cnt_next     = '0;
               w_state_next      = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            // Registered pulse lands exactly KERNEL_SIZE cycles after load_start.
            w_issue_cnt_next = r_issue_cnt + 1'b1;
            if (r_issue_cnt == K_LAST) begin
               w_load_done_next = 1'b1;
               w_state_next     = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (w_fill_done) begin
               if (w_front_free) begin
                  w_kernel_vld_next = 1'b1;
`ifdef WEIGHT_BUF_DOUBLE_EN
                  w_front_sel_next  = !r_front_sel;
                  w_state_next      = ST_IDLE;
`else
                  w_state_next      = ST_HOLD;
`endif
               end else begin
`ifdef WEIGHT_BUF_DOUBLE_EN
                  w_back_full_next  = 1'b1;
`endif
                  w_state_next      = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (w_hs) begin
`ifdef WEIGHT_BUF_DOUBLE_EN
               // Completed back bank replaces the accepted front set.
               w_front_sel_next  = !r_front_sel;
               w_back_full_next  = 1'b0;
               w_kernel_vld_next = 1'b1;
`endif
               w_state_next      = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_issue_cnt  <= '0;
         r_rx_cnt     <= '0;
         r_load_start <= 1'b0;
         r_load_done  <= 1'b0;
         r_kernel_vld <= 1'b0;
`ifdef WEIGHT_BUF_DOUBLE_EN
         r_front_sel  <= 1'b0;
         r_back_full  <= 1'b0;
`endif
      end else begin
         r_state      <= w_state_next;
         r_issue_cnt  <= w_issue_cnt_next;
         r_rx_cnt     <= w_rx_cnt_next;
         r_load_start <= w_load_start_next;
         r_load_done  <= w_load_done_next;
         r_kernel_vld <= w_kernel_vld_next;
`ifdef WEIGHT_BUF_DOUBLE_EN
         r_front_sel  <= w_front_sel_next;
         r_back_full  <= w_back_full_next;
`endif
      end
   end

   assign bus.load_start       = r_load_start;
   assign bus.weight_load_done = r_load_done;
   assign bus.kernel_vld       = r_kernel_vld;
   assign bus.busy             = (r_state != ST_IDLE);
   assign bus.kernel0          = w_front[0];
   assign bus.kernel1          = w_front[1];
   assign bus.kernel2          = w_front[2];
   assign bus.kernel3          = w_front[3];

endmodule

// File: tb/tb_weight_buffer.sv
// -----------------------------------------------------------------------------
// tb_weight_buffer
// Bench for weight_buffer: a KERNEL_SIZE=9 instance and a KERNEL_SIZE=1
// instance sharing clk/rst. Honors WEIGHT_BUF_DOUBLE_EN like the design.
// -----------------------------------------------------------------------------
module tb_weight_buffer;
   import weight_buf_pkg::*;

`ifdef WEIGHT_BUF_DOUBLE_EN
   localparam logic DBL = 1'b1;
`else
   localparam logic DBL = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   weight_buffer_if #(.WEIGHT_WIDTH(8), .KERNEL_SIZE(9)) bus ();
   weight_buffer_if #(.WEIGHT_WIDTH(8), .KERNEL_SIZE(1)) bus1 ();

   weight_buffer #(.WEIGHT_WIDTH(8), .KERNEL_SIZE(9)) u_dut  (.clk(clk), .rst(rst), .bus(bus));
   weight_buffer #(.WEIGHT_WIDTH(8), .KERNEL_SIZE(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

   typedef struct packed {
      logic       fill_req;
      logic       vld;
      logic [7:0] beat;
      logic       x_start;
      logic       x_done;
      logic       x_kvld;
      logic       x_busy;
   } vec_t;

   vec_t tbl [15];

   localparam logic [71:0] KA0 = 72'h080706050403020100;
   localparam logic [71:0] KA3 = 72'h383736353433323130;

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      check(name, 72'(act), 72'(exp));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [71:0] exp_kernel(input logic [7:0] base, input int lane);
      logic [71:0] k;
      k = '0;
      for (int i = 0; i < 9; i++) k[i*8 +: 8] = base + 8'(lane * 16) + 8'(i);
      return k;
   endfunction

   task automatic drive_beat(input logic [7:0] base, input int i);
      bus.weight_vld = 1'b1;
      bus.weight0    = base + 8'(i);
      bus.weight1    = base + 8'h10 + 8'(i);
      bus.weight2    = base + 8'h20 + 8'(i);
      bus.weight3    = base + 8'h30 + 8'(i);
   endtask

   task automatic check_kernels(input string name, input logic [7:0] base);
      check({name, " k0"}, bus.kernel0, exp_kernel(base, 0));
      check({name, " k1"}, bus.kernel1, exp_kernel(base, 1));
      check({name, " k2"}, bus.kernel2, exp_kernel(base, 2));
      check({name, " k3"}, bus.kernel3, exp_kernel(base, 3));
   endtask

   task automatic check_zero(input string name);
      check_bit({name, " load_start"}, bus.load_start, 1'b0);
      check_bit({name, " load_done"}, bus.weight_load_done, 1'b0);
      check_bit({name, " kernel_vld"}, bus.kernel_vld, 1'b0);
      check_bit({name, " busy"}, bus.busy, 1'b0);
      check({name, " k0"}, bus.kernel0, 72'h0);
      check({name, " k3"}, bus.kernel3, 72'h0);
   endtask

   // Bounded wait for load_start; returns the number of cycles waited.
   task automatic wait_start(output int waited);
      waited = 0;
      do begin
         tick();
         waited++;
      end while (!bus.load_start && waited < 40);
      check_bit("load_start seen", bus.load_start, 1'b1);
   endtask

   // Loader model: beats at load_start+LOADER_LAT onward, one per cycle.
   // Returns on the cycle after the last beat (c+KERNEL_SIZE+3).
   task automatic issue_fill(input logic [7:0] base, input logic rdy_on_last);
      int w;
      bus.fill_req = 1'b1;
      wait_start(w);
      bus.fill_req = 1'b0;
      repeat (LOADER_LAT - 1) tick();
      for (int i = 0; i < 9; i++) begin
         tick();
         drive_beat(base, i);
         if (i == 8) bus.kernel_rdy = rdy_on_last;
      end
      tick();
      bus.weight_vld = 1'b0;
      bus.kernel_rdy = 1'b0;
   endtask

   // Called on the load_start cycle s: late loader delivers 5 beats at
   // s+5..s+9, then reset is asserted while the FSM sits in DRAIN.
   task automatic partial_then_reset();
      bus.fill_req = 1'b0;
      repeat (4) tick();
      for (int i = 0; i < 5; i++) begin
         tick();
         drive_beat(8'hC0, i);
      end
      tick();
      bus.weight_vld = 1'b0;
      check_bit("drain busy", bus.busy, 1'b1);
      rst = 1'b1;
      tick();
      check_zero("mid-fill reset");
      rst = 1'b0;
      tick();
   endtask

   initial begin
      int w;
      bus.fill_req = 1'b0; bus.weight_vld = 1'b0; bus.kernel_rdy = 1'b0;
      bus.weight0 = '0; bus.weight1 = '0; bus.weight2 = '0; bus.weight3 = '0;
      bus1.fill_req = 1'b0; bus1.weight_vld = 1'b0; bus1.kernel_rdy = 1'b0;
      bus1.weight0 = '0; bus1.weight1 = '0; bus1.weight2 = '0; bus1.weight3 = '0;

      //          fill vld beat   start done kvld busy
      tbl[0]  = '{1'b1, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 8'd0,  1'b1, 1'b0, 1'b0, 1'b1};
      tbl[2]  = '{1'b1, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 1'b1};
      tbl[3]  = '{1'b1, 1'b1, 8'd0,  1'b0, 1'b0, 1'b0, 1'b1};
      tbl[4]  = '{1'b1, 1'b1, 8'd1,  1'b0, 1'b0, 1'b0, 1'b1};
      tbl[5]  = '{1'b1, 1'b1, 8'd2,  1'b0, 1'b0, 1'b0, 1'b1};
      tbl[6]  = '{1'b1, 1'b1, 8'd3,  1'b0, 1'b0, 1'b0, 1'b1};
      tbl[7]  = '{1'b1, 1'b1, 8'd4,  1'b0, 1'b0, 1'b0, 1'b1};
      tbl[8]  = '{1'b1, 1'b1, 8'd5,  1'b0, 1'b0, 1'b0, 1'b1};
      tbl[9]  = '{1'b1, 1'b1, 8'd6,  1'b0, 1'b0, 1'b0, 1'b1};
      tbl[10] = '{1'b0, 1'b1, 8'd7,  1'b0, 1'b1, 1'b0, 1'b1};
      tbl[11] = '{1'b0, 1'b1, 8'd8,  1'b0, 1'b0, 1'b0, 1'b1};
      tbl[12] = '{1'b0, 1'b1, 8'd9,  1'b0, 1'b0, 1'b1, !DBL};
      tbl[13] = '{1'b0, 1'b1, 8'd10, 1'b0, 1'b0, 1'b1, !DBL};
      tbl[14] = '{1'b0, 1'b0, 8'd0,  1'b0, 1'b0, 1'b1, !DBL};

      repeat (3) tick();
      rst = 1'b0;
      tick();
      check_zero("reset");
      check_bit("reset k1 busy", bus1.busy, 1'b0);
      check_bit("reset k1 kernel_vld", bus1.kernel_vld, 1'b0);
      check("reset k1 kernel0", 72'(bus1.kernel0), 72'h0);

      // Fill A: fill_req sampled at row 0, overshoot beats at rows 12-13.
      for (int t = 0; t < 15; t++) begin
         check_bit($sformatf("t%0d load_start", t), bus.load_start, tbl[t].x_start);
         check_bit($sformatf("t%0d load_done", t), bus.weight_load_done, tbl[t].x_done);
         check_bit($sformatf("t%0d kernel_vld", t), bus.kernel_vld, tbl[t].x_kvld);
         check_bit($sformatf("t%0d busy", t), bus.busy, tbl[t].x_busy);
         bus.fill_req = tbl[t].fill_req;
         if (tbl[t].vld) drive_beat(8'h00, int'(tbl[t].beat));
         else            bus.weight_vld = 1'b0;
         tick();
      end
      check("A kernel0", bus.kernel0, KA0);
      check("A kernel3", bus.kernel3, KA3);
      check_kernels("A", 8'h00);

`ifndef WEIGHT_BUF_DOUBLE_EN
      // Stall: no second fill while the single bank is presented.
      bus.fill_req = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         check_bit("stall kernel_vld", bus.kernel_vld, 1'b1);
         check("stall kernel0", bus.kernel0, KA0);
         check_bit("stall load_start", bus.load_start, 1'b0);
      end
      bus.kernel_rdy = 1'b1;
      tick();
      bus.kernel_rdy = 1'b0;
      check_bit("hs+1 kernel_vld", bus.kernel_vld, 1'b0);
      check_bit("hs+1 load_start", bus.load_start, 1'b0);
      check_bit("hs+1 busy", bus.busy, 1'b0);
      wait_start(w);
      check("hs restart latency", 72'(w), 72'(1));
      partial_then_reset();
`else
      // Second fill B completes into the back bank while A is held.
      issue_fill(8'h40, 1'b0);
      check_bit("B held busy", bus.busy, 1'b1);
      check_bit("B held kernel_vld", bus.kernel_vld, 1'b1);
      check("B held kernel0", bus.kernel0, KA0);
      for (int i = 0; i < 8; i++) begin
         tick();
         check_bit("hold kernel_vld", bus.kernel_vld, 1'b1);
         check("hold kernel0", bus.kernel0, KA0);
         check_bit("hold busy", bus.busy, 1'b1);
      end
      bus.kernel_rdy = 1'b1;
      tick();
      bus.kernel_rdy = 1'b0;
      check_bit("swap kernel_vld", bus.kernel_vld, 1'b1);
      check_kernels("swap B", 8'h40);
      check_bit("swap busy", bus.busy, 1'b0);
      // Handshake of B in the very cycle C completes: C follows with no bubble.
      issue_fill(8'h60, 1'b1);
      check_bit("no-bubble kernel_vld", bus.kernel_vld, 1'b1);
      check_kernels("no-bubble C", 8'h60);
      bus.fill_req = 1'b1;
      wait_start(w);
      partial_then_reset();
`endif

      // Clean fill after the mid-fill reset.
      issue_fill(8'h80, 1'b0);
      check_bit("post-reset kernel_vld", bus.kernel_vld, 1'b1);
      check_kernels("post-reset", 8'h80);

      // KERNEL_SIZE=1 instance.
      bus1.fill_req = 1'b1;
      tick();
      bus1.fill_req = 1'b0;
      check_bit("k1 load_start c+1", bus1.load_start, 1'b1);
      check_bit("k1 load_done c+1", bus1.weight_load_done, 1'b0);
      tick();
      check_bit("k1 load_done c+2", bus1.weight_load_done, 1'b1);
      check_bit("k1 load_start c+2", bus1.load_start, 1'b0);
      tick();
      check_bit("k1 kernel_vld c+3", bus1.kernel_vld, 1'b0);
      bus1.weight_vld = 1'b1;
      bus1.weight0 = 8'hA5; bus1.weight1 = 8'hB6; bus1.weight2 = 8'hC7; bus1.weight3 = 8'hD8;
      tick();
      check_bit("k1 kernel_vld c+4", bus1.kernel_vld, 1'b1);
      check("k1 kernel0", 72'(bus1.kernel0), 72'hA5);
      bus1.weight0 = 8'h11; bus1.weight1 = 8'h22; bus1.weight2 = 8'h33; bus1.weight3 = 8'h44;
      tick();
      bus1.weight_vld = 1'b0;
      check("k1 kernel0 after overshoot", 72'(bus1.kernel0), 72'hA5);
      check("k1 kernel3 after overshoot", 72'(bus1.kernel3), 72'hD8);
      check_bit("k1 kernel_vld held", bus1.kernel_vld, 1'b1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/weight_buffer.md
# weight_buffer

Downstream consumer of the weight loader. It requests a kernel's worth of weights and counts the four-lane weight stream into per-lane kernel registers. It ends the loader's burst with an exactly-timed `weight_load_done`, then presents the complete kernel set to the PE array through a valid/ready handshake.

## Interface
- `WEIGHT_WIDTH`, default 8: bits per weight.
- `KERNEL_SIZE`, default 9: weights per lane per kernel (3x3); legal range 1..255.
- `clk` in, 1: single clock.
- `rst` in, 1: synchronous, active-high reset.
- `fill_req` in, 1: level; controller wants the next kernel set loaded.
- `load_start` out, 1: registered one-cycle pulse to the loader.
- `weight_load_done` out, 1: registered one-cycle pulse to the loader's `load_done`.
- `weight0`..`weight3` in, `WEIGHT_WIDTH`: lane data from the loader.
- `weight_vld` in, 1: lane data valid.
- `kernel0`..`kernel3` out, `KERNEL_SIZE*WEIGHT_WIDTH`: front-bank kernels; beat i sits at `[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]`.
- `kernel_vld` out, 1: front bank holds a complete kernel set.
- `kernel_rdy` in, 1: PE array accepts; transfer on `kernel_vld && kernel_rdy`.
- `busy` out, 1: state is not IDLE.

## Operation
- States: IDLE, ISSUE, DRAIN, HOLD.
- IDLE:
  - Start a fill when `fill_req` is high and the fill bank is free, where free is defined under Configuration.
  - On start: `load_start`=1 for one cycle, clear `issue_cnt` and `rx_cnt`, go to ISSUE.
- ISSUE:
  - `issue_cnt` increments each cycle.
  - `weight_load_done` pulses for one cycle when `issue_cnt` reaches KERNEL_SIZE, which is KERNEL_SIZE cycles after `load_start`. The loader therefore issues exactly KERNEL_SIZE addresses, and its address stays contiguous for the next kernel.
  - Go to DRAIN in the same cycle.
- Receive, valid in ISSUE and DRAIN:
  - Each `weight_vld` beat with `rx_cnt` < KERNEL_SIZE writes `weightN` into the fill bank, lane N, slot `rx_cnt`, then increments `rx_cnt`.
  - Beats outside ISSUE/DRAIN, or beyond KERNEL_SIZE, are dropped.
- DRAIN: when `rx_cnt` == KERNEL_SIZE the fill bank is complete.
  - If the front is empty, the bank becomes the front, `kernel_vld` rises next cycle, and the state goes to IDLE (double-buffered) or HOLD (single).
  - Otherwise go to HOLD.
- HOLD: wait for the front handshake.
  - Double-buffered: swap banks on handshake, then go to IDLE.
  - Single: `kernel_vld` drops, then go to IDLE.
- `kernel_vld` remains high and `kernelN` remain stable until the handshake.
- `fill_req` deasserting mid-fill does not abort the fill.
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Counters 0.
  - Banks zeroed and empty.
- Reset mid-fill discards partial data; the loader shares `rst` and also returns to idle.
- Counter widths: `$clog2(KERNEL_SIZE+1)`; saturating compares, no wrap.

## Timing
- `fill_req` sampled high in IDLE at cycle c:
  - `load_start` at c+1.
  - `weight_load_done` at c+1+KERNEL_SIZE.
  - Loader beats at c+3 .. c+KERNEL_SIZE+2.
  - `kernel_vld` at c+KERNEL_SIZE+3 if the front is empty.
- Handshake at cycle h:
  - Single: `kernel_vld` is 0 at h+1, and the earliest next `load_start` is h+2.
  - Double: the swap takes effect at h+1, with `kernel_vld` high at h+1 if the back bank was complete.
- Simultaneous handshake and DRAIN completion in the same cycle: the completing bank becomes the front at the next edge with no bubble, and `kernel_vld` stays high.
- KERNEL_SIZE=1: `weight_load_done` is coincident with the loader's first address cycle (c+2).

## Configuration
- `WEIGHT_BUF_DOUBLE_EN` defined:
  - Two banks in ping-pong operation.
  - The fill bank is free when the back bank is not complete, so the next kernel loads while the PE array uses the front.
- Undefined:
  - One bank.
  - The fill bank is free only when `kernel_vld`=0.
  - A fill never overlaps presentation.

## Structure
- Package `weight_buf_pkg`:
  - State enum.
  - `LANES`=4.
  - `LOADER_LAT`=2, the cycles from `load_start` to the first beat.
  - Counter-width function.
- Sub-module `weight_bank`: 4 lanes × KERNEL_SIZE registers, write-enable plus slot index, flattened outputs. Instantiated once or twice depending on the macro.

## Test plan
- Single fill, KERNEL_SIZE=9, beat i lanes = {i, 0x10+i, 0x20+i, 0x30+i}:
  - Check `load_start` at c+1 and `weight_load_done` at c+10.
  - Check `kernel_vld` at c+12.
  - Check `kernel0` = 0x080706050403020100.
- Two extra `weight_vld` beats after the 9th (loader overshoot) -> dropped; `rx_cnt` stays 9 and the kernels are unchanged.
- `kernel_rdy` held low for 20 cycles -> `kernel_vld` and data stable.
  - Single: no second `load_start` while `fill_req` is high.
  - Double: the second fill completes and waits in HOLD.
- Double-buffered: back-to-back kernels A and B with `kernel_rdy`=1 -> B presented the cycle after A's handshake, no bubble.
- `rst` asserted in DRAIN after 5 beats -> all outputs 0 the next cycle, and the next fill yields a clean 9-beat kernel.
- KERNEL_SIZE=1 -> `weight_load_done` at c+2, exactly one beat captured, `kernel_vld` at c+4.
